// File: rtl/sync_fifo_if.sv
// Handshake bundle for sync_fifo: write/read requests, registered status and occupancy flags.
// The master modport drives requests; the slave modport is the FIFO side.
interface sync_fifo_if #(
   parameter int unsigned FIFO_WIDTH = 16
) ();

   logic [FIFO_WIDTH-1:0] data_in;
   logic                  wr_en;
   logic                  rd_en;
   logic [FIFO_WIDTH-1:0] data_out;
   logic                  wr_ack;
   logic                  overflow;
   logic                  underflow;
   logic                  full;
   logic                  empty;
   logic                  almostfull;
   logic                  almostempty;

   modport master (
      output data_in,
      output wr_en,
      output rd_en,
      input  data_out,
      input  wr_ack,
      input  overflow,
      input  underflow,
      input  full,
      input  empty,
      input  almostfull,
      input  almostempty
   );

   modport slave (
      input  data_in,
      input  wr_en,
      input  rd_en,
      output data_out,
      output wr_ack,
      output overflow,
      output underflow,
      output full,
      output empty,
      output almostfull,
      output almostempty
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and write/overflow/underflow status.
// Define SYNC_FIFO_ASSERT_EN to compile in embedded assertions and cover points.
module sync_fifo #(
   parameter int unsigned FIFO_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input logic       clk,
   input logic       rst_n,
   sync_fifo_if.slave bus
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [CW-1:0] CntFull  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CntAFull = CW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] CntOne   = CW'(1);
   localparam logic [AW-1:0] PtrLast  = AW'(FIFO_DEPTH - 1);
   localparam logic [AW-1:0] PtrOne   = AW'(1);

   logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [FIFO_WIDTH-1:0] data_out_q;
   logic                  wr_ack_q, overflow_q, underflow_q;

   logic full, empty, almostfull, almostempty;
   logic wr_accept, rd_accept;

   // Occupancy flags decode straight from the count so they track it within the cycle.
   always_comb begin
      full        = (count_q == CntFull);
      empty       = (count_q == '0);
      almostfull  = (count_q == CntAFull);
      almostempty = (count_q == CntOne);
   end

   always_comb begin
      wr_accept = bus.wr_en && !full;
      rd_accept = bus.rd_en && !empty;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + PtrOne;
      end
      // A simultaneous accepted write and read leaves occupancy unchanged.
      unique case ({wr_accept, rd_accept})
         2'b10:   count_d = count_q + CntOne;
         2'b01:   count_d = count_q - CntOne;
         default: count_d = count_q;
      endcase
   end

   // Storage is deliberately not reset; stale words are unreachable until rewritten.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr_q] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         data_out_q  <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         wr_ack_q    <= wr_accept;
         overflow_q  <= bus.wr_en && full;
         underflow_q <= bus.rd_en && empty;
         if (rd_accept) begin
            data_out_q <= mem[rd_ptr_q];
         end
      end
   end

   always_comb begin
      bus.data_out    = data_out_q;
      bus.wr_ack      = wr_ack_q;
      bus.overflow    = overflow_q;
      bus.underflow   = underflow_q;
      bus.full        = full;
      bus.empty       = empty;
      bus.almostfull  = almostfull;
      bus.almostempty = almostempty;
   end

`ifdef SYNC_FIFO_ASSERT_EN

   a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= CntFull);

   a_full_empty_excl: assert property (@(posedge clk)
      !(full && empty));

   a_ack_ovf_excl: assert property (@(posedge clk)
      !(wr_ack_q && overflow_q));

   a_rd_uf_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(rd_accept && underflow_q && empty));

   // Sampled on the edge while reset is held, so the async clear must already be visible.
   a_reset_clear: assert property (@(posedge clk)
      !rst_n |-> (count_q == '0 && wr_ptr_q == '0 && rd_ptr_q == '0 && !wr_ack_q
                  && !overflow_q && !underflow_q && empty && !full));

   a_count_hold_both: assert property (@(posedge clk) disable iff (!rst_n)
      (wr_accept && rd_accept) |=> $stable(count_q));

   c_full:      cover property (@(posedge clk) disable iff (!rst_n) full);
   c_empty:     cover property (@(posedge clk) disable iff (!rst_n) empty);
   c_overflow:  cover property (@(posedge clk) disable iff (!rst_n) overflow_q);
   c_underflow: cover property (@(posedge clk) disable iff (!rst_n) underflow_q);
   c_wr_wrap:   cover property (@(posedge clk) disable iff (!rst_n)
      wr_accept && wr_ptr_q == PtrLast);
   c_rd_wrap:   cover property (@(posedge clk) disable iff (!rst_n)
      rd_accept && rd_ptr_q == PtrLast);

`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed scoreboard bench for sync_fifo (16x8): stimulus queues expected per-cycle results,
// a monitor pops and compares them on the falling clock edge or right after an async reset.
module tb_sync_fifo;

   logic clk;
   logic rst_n;
   int   cycle;
   int   n_vec;
   int   n_fail;

   typedef struct {
      int          tgt;
      string       tag;
      bit          chkd;
      logic [15:0] data;
      logic        ack;
      logic        ov;
      logic        un;
      int          occ;
   } exp_t;

   exp_t exp_q[$];

   sync_fifo_if #(.FIFO_WIDTH(16)) bus ();

   sync_fifo #(
      .FIFO_WIDTH(16),
      .FIFO_DEPTH(8)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input string tag, input logic [15:0] got,
                      input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s [%s] got %h expected %h", name, tag, got, want);
      end
   endtask

   task automatic compare(input exp_t e);
      if (e.chkd) chk("data_out", e.tag, bus.data_out, e.data);
      chk("wr_ack", e.tag, 16'(bus.wr_ack), 16'(e.ack));
      chk("overflow", e.tag, 16'(bus.overflow), 16'(e.ov));
      chk("underflow", e.tag, 16'(bus.underflow), 16'(e.un));
      chk("full", e.tag, 16'(bus.full), 16'(e.occ == 8));
      chk("empty", e.tag, 16'(bus.empty), 16'(e.occ == 0));
      chk("almostfull", e.tag, 16'(bus.almostfull), 16'(e.occ == 7));
      chk("almostempty", e.tag, 16'(bus.almostempty), 16'(e.occ == 1));
   endtask

   // Monitor: also wakes on a falling reset so an async clear is checked before the next edge.
   initial begin
      exp_t e;
      n_vec  = 0;
      n_fail = 0;
      forever begin
         @(negedge clk or negedge rst_n);
         #1;
         while (exp_q.size() > 0 && exp_q[0].tgt <= cycle) begin
            e = exp_q.pop_front();
            if (e.tgt < cycle) begin
               n_vec++;
               n_fail++;
               $display("FAIL late_check [%s] got cycle %0d expected cycle %0d",
                        e.tag, cycle, e.tgt);
            end else begin
               compare(e);
            end
         end
      end
   end

   task automatic push(input int tgt, input string tag, input bit chkd, input logic [15:0] ed,
                       input logic ack, input logic ov, input logic un, input int occ);
      exp_t e;
      e.tgt  = tgt;
      e.tag  = tag;
      e.chkd = chkd;
      e.data = ed;
      e.ack  = ack;
      e.ov   = ov;
      e.un   = un;
      e.occ  = occ;
      exp_q.push_back(e);
   endtask

   // Called at posedge+1; drives one cycle of stimulus and queues the post-edge expectation.
   task automatic step(input logic w, input logic r, input logic [15:0] d, input string tag,
                       input bit chkd, input logic [15:0] ed, input logic ack, input logic ov,
                       input logic un, input int occ);
      bus.wr_en   = w;
      bus.rd_en   = r;
      bus.data_in = d;
      push(cycle + 1, tag, chkd, ed, ack, ov, un, occ);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected $finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      rst_n       = 1'b0;
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.data_in = '0;

      @(posedge clk);
      #1;
      push(cycle, "reset", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fill to full, then one rejected write.
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 1'b0, 16'(i), $sformatf("fill%0d", i), 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, i);
      end
      step(1'b1, 1'b0, 16'hDEAD, "wr_full", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 8);

      // Drain in order, then one rejected read with data held.
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 1'b1, 16'h0, $sformatf("drain%0d", i), 1'b1, 16'(i), 1'b0, 1'b0, 1'b0,
              8 - i);
      end
      step(1'b0, 1'b1, 16'h0, "rd_empty", 1'b1, 16'h0008, 1'b0, 1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 16'h0, "idle", 1'b1, 16'h0008, 1'b0, 1'b0, 1'b0, 0);

      // Wrap-around: three rounds of five writes then five reads.
      for (int rep = 0; rep < 3; rep++) begin
         for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 16'h0100 + 16'(rep * 5 + k + 1), $sformatf("wrap_w%0d_%0d", rep, k),
                 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, k + 1);
         end
         for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 16'h0, $sformatf("wrap_r%0d_%0d", rep, k), 1'b1,
                 16'h0100 + 16'(rep * 5 + k + 1), 1'b0, 1'b0, 1'b0, 4 - k);
         end
      end

      // Hold four entries, then simultaneous read/write for ten cycles.
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 16'h0201 + 16'(k), $sformatf("pre_w%0d", k), 1'b0, 16'h0, 1'b1, 1'b0,
              1'b0, k + 1);
      end
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 1'b1, 16'h0205 + 16'(k), $sformatf("both%0d", k), 1'b1, 16'h0201 + 16'(k),
              1'b1, 1'b0, 1'b0, 4);
      end
      // Remaining contents 0x020B..0x020E; top up to full.
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 16'h0211 + 16'(k), $sformatf("top_w%0d", k), 1'b0, 16'h0, 1'b1, 1'b0,
              1'b0, 5 + k);
      end
      step(1'b1, 1'b1, 16'hBEEF, "both_full", 1'b1, 16'h020B, 1'b0, 1'b1, 1'b0, 7);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, 16'h0, $sformatf("dr_a%0d", k), 1'b1, 16'h020C + 16'(k), 1'b0, 1'b0,
              1'b0, 6 - k);
      end
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 16'h0, $sformatf("dr_b%0d", k), 1'b1, 16'h0211 + 16'(k), 1'b0, 1'b0,
              1'b0, 3 - k);
      end
      // Written word must not bypass to data_out.
      step(1'b1, 1'b1, 16'h0300, "both_empty", 1'b1, 16'h0214, 1'b1, 1'b0, 1'b1, 1);
      step(1'b0, 1'b1, 16'h0, "rd_after_be", 1'b1, 16'h0300, 1'b0, 1'b0, 1'b0, 0);

      // Reset mid-operation, asserted between clock edges.
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b0, 16'h0401 + 16'(k), $sformatf("pre_rst%0d", k), 1'b0, 16'h0, 1'b1, 1'b0,
              1'b0, k + 1);
      end
      @(negedge clk);
      #2;
      bus.wr_en = 1'b0;
      push(cycle, "mid_reset", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b0, 1'b1, 16'h0, "rd_post_rst", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 16'h0, "idle_post_rst", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 0);

      repeat (2) @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_fail++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 16, meaning data word width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning number of storage entries (power of two, >=4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 data_in  input  FIFO_WIDTH  write data.
REQ-006 wr_en  input  1  write request.
REQ-007 rd_en  input  1  read request.
REQ-008 data_out  output  FIFO_WIDTH  registered read data.
REQ-009 wr_ack  output  1  registered; previous-cycle write accepted.
REQ-010 overflow  output  1  registered; previous-cycle write rejected because full.
REQ-011 underflow  output  1  registered; previous-cycle read rejected because empty.
REQ-012 full, empty, almostfull, almostempty  output  1 each  combinational occupancy flags.

Function
REQ-013 Internal count SHALL be $clog2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH; wr_ptr/rd_ptr $clog2(FIFO_DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-014 full = (count==FIFO_DEPTH); empty = (count==0); almostfull = (count==FIFO_DEPTH-1); almostempty = (count==1).
REQ-015 wr_en && !full: mem[wr_ptr] <= data_in, wr_ptr+1, wr_ack<=1, overflow<=0.
REQ-016 wr_en && full: no storage/pointer change, wr_ack<=0, overflow<=1.
REQ-017 !wr_en: wr_ack<=0, overflow<=0.
REQ-018 rd_en && !empty: data_out <= mem[rd_ptr] (1-cycle latency), rd_ptr+1, underflow<=0.
REQ-019 rd_en && empty: data_out holds, underflow<=1; !rd_en: underflow<=0, data_out holds.
REQ-020 Simultaneous wr_en && rd_en, neither full nor empty: both succeed, count unchanged.
REQ-021 Simultaneous when full: read succeeds, write rejected (overflow<=1), count DEPTH-1.
REQ-022 Simultaneous when empty: write succeeds, read rejected (underflow<=1), count 1; written word not bypassed to data_out.
REQ-023 Count SHALL increment only on accepted-write-only, decrement only on accepted-read-only.
REQ-024 Data SHALL be returned in strict write order across pointer wrap-around.

Reset
REQ-025 rst_n low SHALL immediately clear wr_ptr, rd_ptr, count, data_out, wr_ack, overflow, underflow to 0, regardless of clk.
REQ-026 During/after reset: empty=1, full=0, almostfull=0, almostempty=0; memory contents not reset and never observable before rewrite.
REQ-027 Reset asserted mid-operation SHALL discard all stored words; first read after release with no write gives underflow=1.

Configuration
REQ-028 Macro SYNC_FIFO_ASSERT_EN defined: block SHALL contain embedded concurrent assertions (count<=DEPTH; full&&empty never both 1; wr_ack&&overflow never both 1; reset clears count/flags) plus cover points on full, empty, overflow, underflow, wrap.
REQ-029 Macro undefined: no assertion/cover code compiled; ports and cycle behaviour identical.

Verification (FIFO_WIDTH=16, FIFO_DEPTH=8)
REQ-030 Reset, then 8 writes 0x0001..0x0008 -> wr_ack=1 each cycle after; almostfull after 7th, full=1 after 8th; 9th write 0xDEAD -> overflow=1, wr_ack=0.
REQ-031 From full, 8 reads -> data_out 0x0001..0x0008 in order one cycle after each rd_en; empty=1 after 8th; 9th read -> underflow=1, data_out stays 0x0008.
REQ-032 Write 5, read 5, repeat 3 times with values 0x0100+n -> pointers wrap, all 15 values out in order, no overflow/underflow.
REQ-033 Hold 4 entries, assert wr_en&&rd_en for 10 cycles -> count stays 4, data order preserved; at full with both -> overflow=1 and one word read; at empty with both -> underflow=1, count=1.
REQ-034 Write 6 words, assert rst_n=0 between clock edges -> outputs and count clear immediately (empty=1); after release, rd_en -> underflow=1.
REQ-035 Build with and without SYNC_FIFO_ASSERT_EN -> identical output traces on REQ-030..034; no assertion fires in assertion build.
